// File: rtl/dcache_pkg.sv
`default_nettype none
// ============================================================================
// Module   : dcache_pkg
// Purpose  : Shared geometry, FSM state codes and line-metadata type for the
//            direct-mapped write-back L1 data cache.
// Ports    : none (package)
// Revision : 1.0  initial release
// ============================================================================
package dcache_pkg;

   localparam int NUM_LINES  = 16;
   localparam int LINE_BYTES = 32;
   localparam int IDX_W      = $clog2(NUM_LINES);
   localparam int OFF_W      = $clog2(LINE_BYTES);
   localparam int TAG_W      = 32 - IDX_W - OFF_W;
   localparam int LINE_W     = LINE_BYTES * 8;
   localparam int WSEL_W     = OFF_W - 2;

   // Controller states
   localparam logic [1:0] ST_IDLE      = 2'd0;
   localparam logic [1:0] ST_MISS      = 2'd1;
   localparam logic [1:0] ST_WRITEBACK = 2'd2;
   localparam logic [1:0] ST_ALLOCATE  = 2'd3;

   typedef struct packed {
      logic             valid;
      logic             dirty;
      logic [TAG_W-1:0] tag;
   } line_meta_t;

endpackage
`default_nettype wire

// File: rtl/dcache_if.sv
`default_nettype none
// ============================================================================
// Module   : dcache_if
// Purpose  : Bundles the CPU-side request bus and the off-chip line-memory bus
//            of the data cache.
// Ports    : cpu_addr_i/cpu_data_i/cpu_MemRead_i/cpu_MemWrite_i -> cache
//            cpu_data_o/cpu_stall_o                             <- cache
//            mem_addr_o/mem_data_o/mem_enable_o/mem_write_o     <- cache
//            mem_data_i/mem_ack_i                               -> cache
//            modport slave  : the cache itself
//            modport master : the environment (CPU + memory)
// Revision : 1.0  initial release
// ============================================================================
interface dcache_if;

   logic [31:0]                 cpu_addr_i;
   logic [31:0]                 cpu_data_i;
   logic                        cpu_MemRead_i;
   logic                        cpu_MemWrite_i;
   logic [31:0]                 cpu_data_o;
   logic                        cpu_stall_o;
   logic [31:0]                 mem_addr_o;
   logic [dcache_pkg::LINE_W-1:0] mem_data_o;
   logic                        mem_enable_o;
   logic                        mem_write_o;
   logic [dcache_pkg::LINE_W-1:0] mem_data_i;
   logic                        mem_ack_i;

   modport slave (
      input  cpu_addr_i, cpu_data_i, cpu_MemRead_i, cpu_MemWrite_i,
      input  mem_data_i, mem_ack_i,
      output cpu_data_o, cpu_stall_o,
      output mem_addr_o, mem_data_o, mem_enable_o, mem_write_o
   );

   modport master (
      output cpu_addr_i, cpu_data_i, cpu_MemRead_i, cpu_MemWrite_i,
      output mem_data_i, mem_ack_i,
      input  cpu_data_o, cpu_stall_o,
      input  mem_addr_o, mem_data_o, mem_enable_o, mem_write_o
   );

endinterface
`default_nettype wire

// File: rtl/dcache_sram.sv
`default_nettype none
// ============================================================================
// Module   : dcache_sram
// Purpose  : Tag/valid/dirty array plus 256-bit line data array of the cache.
//            One combinational read port by index, one synchronous write port
//            with separate metadata and data enables; data writes are either
//            a full line or a single 32-bit word.
// Ports    : clk_i, rst_i          clock, sync active-high reset (clears meta)
//            rd_idx_i              read index
//            rd_meta_o, rd_line_o  metadata and line at rd_idx_i
//            wr_idx_i              write index
//            meta_we_i, wr_meta_i  metadata write
//            data_we_i             data write enable
//            data_full_i           1 = whole line from wr_line_i, 0 = one word
//            wr_word_i             word select for single-word writes
//            wr_line_i             full-line write data
//            wr_word_data_i        single-word write data
// Revision : 1.0  initial release
// ============================================================================
module dcache_sram
   import dcache_pkg::*;
(
   input  wire logic              clk_i,
   input  wire logic              rst_i,
   input  wire logic [IDX_W-1:0]  rd_idx_i,
   output line_meta_t             rd_meta_o,
   output logic [LINE_W-1:0]      rd_line_o,
   input  wire logic [IDX_W-1:0]  wr_idx_i,
   input  wire logic              meta_we_i,
   input  line_meta_t             wr_meta_i,
   input  wire logic              data_we_i,
   input  wire logic              data_full_i,
   input  wire logic [WSEL_W-1:0] wr_word_i,
   input  wire logic [LINE_W-1:0] wr_line_i,
   input  wire logic [31:0]       wr_word_data_i
);

   line_meta_t        meta_arr [NUM_LINES];
   logic [LINE_W-1:0] data_arr [NUM_LINES];

   for (genvar i = 0; i < NUM_LINES; i++) begin : g_line
      line_meta_t        meta_q, meta_d;
      logic [LINE_W-1:0] data_q, data_d;
      logic              sel;

      assign sel = (wr_idx_i == IDX_W'(i));

      always_comb begin
         meta_d = meta_q;
         data_d = data_q;
         if (meta_we_i && sel) begin
            meta_d = wr_meta_i;
         end
         if (data_we_i && sel) begin
            if (data_full_i) begin
               data_d = wr_line_i;
            end else begin
               data_d[{wr_word_i, 5'b0} +: 32] = wr_word_data_i;
            end
         end
      end

      // Only metadata is reset; stale data is harmless once valid is clear.
      always_ff @(posedge clk_i) begin
         if (rst_i) begin
            meta_q <= '0;
         end else begin
            meta_q <= meta_d;
         end
      end

      always_ff @(posedge clk_i) begin
         data_q <= data_d;
      end

      assign meta_arr[i] = meta_q;
      assign data_arr[i] = data_q;
   end

   assign rd_meta_o = meta_arr[rd_idx_i];
   assign rd_line_o = data_arr[rd_idx_i];

endmodule
`default_nettype wire

// File: rtl/dcache_controller.sv
`default_nettype none
// ============================================================================
// Module   : dcache_controller
// Purpose  : Direct-mapped, write-back, write-allocate L1 data cache. Hits are
//            served combinationally; a miss stalls the pipeline while the FSM
//            writes back a dirty victim and refills the line.
// Ports    : clk_i  clock
//            rst_i  synchronous active-high reset
//            bus    dcache_if.slave (CPU request bus + line-memory bus)
// Revision : 1.0  initial release
// ============================================================================
module dcache_controller
   import dcache_pkg::*;
(
   input  wire logic clk_i,
   input  wire logic rst_i,
   dcache_if.slave   bus
);

   logic [1:0]        state_q, state_d;

   logic [TAG_W-1:0]  req_tag;
   logic [IDX_W-1:0]  req_idx;
   logic [WSEL_W-1:0] req_word;
   logic              req, is_write, hit;

   line_meta_t        rd_meta, wr_meta;
   logic [LINE_W-1:0] rd_line;
   logic              meta_we, data_we, data_full;
   logic              unused_addr_bits;

   assign req_tag  = bus.cpu_addr_i[31 -: TAG_W];
   assign req_idx  = bus.cpu_addr_i[OFF_W +: IDX_W];
   assign req_word = bus.cpu_addr_i[2 +: WSEL_W];
   assign unused_addr_bits = ^bus.cpu_addr_i[1:0];

   assign req      = bus.cpu_MemRead_i | bus.cpu_MemWrite_i;
   // A simultaneous read+write is treated as a write.
   assign is_write = bus.cpu_MemWrite_i;
   assign hit      = req & rd_meta.valid & (rd_meta.tag == req_tag);

   dcache_sram u_sram (
      .clk_i          (clk_i),
      .rst_i          (rst_i),
      .rd_idx_i       (req_idx),
      .rd_meta_o      (rd_meta),
      .rd_line_o      (rd_line),
      .wr_idx_i       (req_idx),
      .meta_we_i      (meta_we),
      .wr_meta_i      (wr_meta),
      .data_we_i      (data_we),
      .data_full_i    (data_full),
      .wr_word_i      (req_word),
      .wr_line_i      (bus.mem_data_i),
      .wr_word_data_i (bus.cpu_data_i)
   );

   always_comb begin
      state_d          = state_q;
      meta_we          = 1'b0;
      wr_meta          = rd_meta;
      data_we          = 1'b0;
      data_full        = 1'b0;
      bus.mem_enable_o = 1'b0;
      bus.mem_write_o  = 1'b0;
      bus.mem_addr_o   = '0;
      case (state_q)
         ST_IDLE: begin
            if (req && !hit) begin
               state_d = ST_MISS;
            end else if (hit && is_write) begin
               meta_we       = 1'b1;
               wr_meta.dirty = 1'b1;
               data_we       = 1'b1;
            end
         end
         // Idle-bus gap cycle: separates write-back from refill.
         ST_MISS: begin
            state_d = (rd_meta.valid && rd_meta.dirty) ? ST_WRITEBACK : ST_ALLOCATE;
         end
         ST_WRITEBACK: begin
            bus.mem_enable_o = 1'b1;
            bus.mem_write_o  = 1'b1;
            bus.mem_addr_o   = {rd_meta.tag, req_idx, {OFF_W{1'b0}}};
            if (bus.mem_ack_i) begin
               meta_we       = 1'b1;
               wr_meta.dirty = 1'b0;
               state_d       = ST_MISS;
            end
         end
         ST_ALLOCATE: begin
            bus.mem_enable_o = 1'b1;
            bus.mem_addr_o   = {req_tag, req_idx, {OFF_W{1'b0}}};
            if (bus.mem_ack_i) begin
               meta_we       = 1'b1;
               wr_meta.valid = 1'b1;
               wr_meta.dirty = 1'b0;
               wr_meta.tag   = req_tag;
               data_we       = 1'b1;
               data_full     = 1'b1;
               state_d       = ST_IDLE;
            end
         end
         default: state_d = ST_IDLE;
      endcase
   end

   always_ff @(posedge clk_i) begin
      if (rst_i) begin
         state_q <= ST_IDLE;
      end else begin
         state_q <= state_d;
      end
   end

   // The victim line is only meaningful while a write-back is in flight.
   assign bus.mem_data_o  = rd_line;
   assign bus.cpu_stall_o = (req && !hit && (state_q == ST_IDLE)) || (state_q != ST_IDLE);
   assign bus.cpu_data_o  = (bus.cpu_MemRead_i && hit) ? rd_line[{req_word, 5'b0} +: 32] : 32'd0;

   a_rd_wr_exclusive: assert property (@(posedge clk_i) disable iff (rst_i)
      !(bus.cpu_MemRead_i && bus.cpu_MemWrite_i));

endmodule
`default_nettype wire

// File: tb/tb_dcache_controller.sv
`default_nettype none
// ============================================================================
// Module   : tb_dcache_controller
// Purpose  : Self-checking bench for dcache_controller: directed scenarios
//            plus randomized loads/stores against a line-level cache model.
// Ports    : none
// Revision : 1.0  initial release
// ============================================================================
module tb_dcache_controller;
   import dcache_pkg::*;

   typedef logic [255:0] line_t;
   typedef struct {
      logic [31:0] addr;
      logic        wr;
      line_t       data;
      int          n;
      int          t_start;
      int          t_end;
   } txn_t;

   logic clk = 1'b0;
   logic rst;
   always #5 clk = ~clk;

   dcache_if bus();
   dcache_controller dut (.clk_i(clk), .rst_i(rst), .bus(bus));

   int n_cmp  = 0;
   int n_fail = 0;
   int cyc    = 0;
   always @(posedge clk) cyc <= cyc + 1;

   task automatic chk(input string name, input logic [255:0] act, input logic [255:0] exp);
      n_cmp++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0h, expected %0h", name, act, exp);
      end
   endtask

   // Backing store seen by the memory responder, and the model's own copy.
   line_t phys_mem [int unsigned];
   line_t exp_mem  [int unsigned];

   function automatic line_t init_line(input int unsigned la);
      line_t l;
      for (int k = 0; k < 8; k++) l[k*32 +: 32] = la * 32'h9E3779B1 + k * 32'h01010101 + 32'h1234;
      return l;
   endfunction
   function automatic line_t read_phys(input int unsigned la);
      if (phys_mem.exists(la)) return phys_mem[la];
      return init_line(la);
   endfunction
   function automatic line_t read_exp(input int unsigned la);
      if (exp_mem.exists(la)) return exp_mem[la];
      return init_line(la);
   endfunction

   // Cache model: per-line valid/dirty/tag/data
   bit          m_valid [NUM_LINES];
   bit          m_dirty [NUM_LINES];
   int unsigned m_tag   [NUM_LINES];
   line_t       m_line  [NUM_LINES];

   txn_t txn_q[$];
   txn_t last_txn[$];
   int   lat_q[$];
   bit   stray_mode = 1'b0;
   int   last_stall;
   logic [31:0] last_rdata;

   // Memory responder and per-cycle output checks
   initial begin : responder
      int   cnt;
      int   lat;
      txn_t cur;
      cnt = 0;
      lat = 1;
      bus.mem_ack_i  = 1'b0;
      bus.mem_data_i = '0;
      forever begin
         @(negedge clk);
         bus.mem_ack_i = 1'b0;
         for (int k = 0; k < 8; k++) bus.mem_data_i[k*32 +: 32] = $urandom();
         if (!bus.cpu_MemRead_i) chk("data_zero_no_read", bus.cpu_data_o, 0);
         if (!rst && !bus.cpu_MemRead_i && !bus.cpu_MemWrite_i) chk("stall_no_req", bus.cpu_stall_o, 0);
         if (rst) begin
            cnt = 0;
         end else if (stray_mode) begin
            chk("stray_enable", bus.mem_enable_o, 0);
            bus.mem_ack_i = 1'($urandom_range(0, 1));
         end else if (cnt != 0 && !bus.mem_enable_o) begin
            chk("enable_held", bus.mem_enable_o, 1);
            cnt = 0;
         end else if (bus.mem_enable_o) begin
            chk("mem_addr_align", bus.mem_addr_o[4:0], 0);
            if (cnt == 0) begin
               cur.addr    = bus.mem_addr_o;
               cur.wr      = bus.mem_write_o;
               cur.data    = bus.mem_data_o;
               cur.t_start = cyc;
               lat = (lat_q.size() != 0) ? lat_q.pop_front() : int'($urandom_range(1, 4));
            end else begin
               chk("mem_addr_stable", bus.mem_addr_o, cur.addr);
               chk("mem_write_stable", bus.mem_write_o, cur.wr);
            end
            cnt++;
            if (cnt >= lat) begin
               bus.mem_ack_i = 1'b1;
               if (cur.wr) phys_mem[cur.addr >> 5] = cur.data;
               else        bus.mem_data_i = read_phys(cur.addr >> 5);
               cur.n     = cnt;
               cur.t_end = cyc;
               txn_q.push_back(cur);
               cnt = 0;
            end
         end
      end
   end

   // One CPU access; called just after a rising edge, returns just after one.
   task automatic do_op(input bit wr, input logic [31:0] addr, input logic [31:0] wdata);
      int unsigned la  = addr / 32;
      int unsigned idx = la % NUM_LINES;
      int unsigned tag = la / NUM_LINES;
      int unsigned w   = (addr % 32) / 4;
      bit   hit = m_valid[idx] && (m_tag[idx] == tag);
      txn_t exp_q[$];
      txn_t e;
      int   stalls = 0;
      int   nsum   = 0;
      int   exp_stall;
      if (!hit) begin
         if (m_valid[idx] && m_dirty[idx]) begin
            e.addr = (m_tag[idx] * NUM_LINES + idx) * 32;
            e.wr   = 1'b1;
            e.data = m_line[idx];
            exp_q.push_back(e);
            exp_mem[m_tag[idx] * NUM_LINES + idx] = m_line[idx];
         end
         e.addr = la * 32;
         e.wr   = 1'b0;
         e.data = '0;
         exp_q.push_back(e);
         m_line[idx]  = read_exp(la);
         m_tag[idx]   = tag;
         m_valid[idx] = 1'b1;
         m_dirty[idx] = 1'b0;
      end
      bus.cpu_addr_i     = addr;
      bus.cpu_data_i     = wdata;
      bus.cpu_MemWrite_i = wr;
      bus.cpu_MemRead_i  = !wr;
      forever begin
         @(negedge clk);
         if (!bus.cpu_stall_o) break;
         stalls++;
         if (stalls > 300) begin
            chk("stall_timeout", bus.cpu_stall_o, 0);
            break;
         end
      end
      chk("txn_count", txn_q.size(), exp_q.size());
      for (int i = 0; i < exp_q.size() && i < txn_q.size(); i++) begin
         chk("txn_addr", txn_q[i].addr, exp_q[i].addr);
         chk("txn_write", txn_q[i].wr, exp_q[i].wr);
         if (exp_q[i].wr) chk("wb_data", txn_q[i].data, exp_q[i].data);
         nsum += txn_q[i].n;
      end
      exp_stall = hit ? 0 : (nsum + ((exp_q.size() == 2) ? 3 : 2));
      chk("stall_cycles", stalls, exp_stall);
      if (exp_q.size() == 2 && txn_q.size() == 2)
         chk("wb_refill_gap", txn_q[1].t_start, txn_q[0].t_end + 2);
      last_txn = txn_q;
      txn_q.delete();
      if (wr) begin
         m_line[idx][w*32 +: 32] = wdata;
         m_dirty[idx] = 1'b1;
      end else begin
         chk("load_data", bus.cpu_data_o, m_line[idx][w*32 +: 32]);
      end
      last_rdata = bus.cpu_data_o;
      last_stall = stalls;
      @(posedge clk);
      #1;
      bus.cpu_MemRead_i  = 1'b0;
      bus.cpu_MemWrite_i = 1'b0;
   endtask

   initial begin
      #1_000_000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   initial begin : main
      line_t l;
      int    waited;
      rst                = 1'b1;
      bus.cpu_addr_i     = '0;
      bus.cpu_data_i     = '0;
      bus.cpu_MemRead_i  = 1'b0;
      bus.cpu_MemWrite_i = 1'b0;
      for (int i = 0; i < NUM_LINES; i++) begin
         m_valid[i] = 1'b0;
         m_dirty[i] = 1'b0;
         m_tag[i]   = 0;
      end
      repeat (3) @(posedge clk);
      #1 rst = 1'b0;
      @(negedge clk);
      chk("rst_stall", bus.cpu_stall_o, 0);
      chk("rst_enable", bus.mem_enable_o, 0);
      chk("rst_write", bus.mem_write_o, 0);
      chk("rst_data", bus.cpu_data_o, 0);
      @(posedge clk);
      #1;

      // Clean refill, ack on 4th enable cycle
      lat_q.push_back(4);
      do_op(1'b0, 32'h40, 32'h0);
      l = init_line(2);
      chk("t1_stall", last_stall, 6);
      chk("t1_txns", last_txn.size(), 1);
      if (last_txn.size() >= 1) begin
         chk("t1_addr", last_txn[0].addr, 32'h40);
         chk("t1_wr", last_txn[0].wr, 0);
      end
      chk("t1_data", last_rdata, l[31:0]);

      // Store hit then load hit
      do_op(1'b1, 32'h44, 32'hDEADBEEF);
      chk("t2_store_stall", last_stall, 0);
      do_op(1'b0, 32'h44, 32'h0);
      chk("t2_load_stall", last_stall, 0);
      chk("t2_load_data", last_rdata, 32'hDEADBEEF);

      // Dirty conflict: write-back 2 cycles, refill 1 cycle
      lat_q.push_back(2);
      lat_q.push_back(1);
      do_op(1'b0, 32'h240, 32'h0);
      chk("t3_stall", last_stall, 6);
      chk("t3_txns", last_txn.size(), 2);
      if (last_txn.size() == 2) begin
         chk("t3_wb_addr", last_txn[0].addr, 32'h40);
         chk("t3_wb_wr", last_txn[0].wr, 1);
         chk("t3_wb_word1", last_txn[0].data[63:32], 32'hDEADBEEF);
         chk("t3_refill_addr", last_txn[1].addr, 32'h240);
      end

      // Ack on first enable cycle
      lat_q.push_back(1);
      do_op(1'b0, 32'h80, 32'h0);
      chk("t4_stall", last_stall, 3);
      if (last_txn.size() >= 1) chk("t4_enable_cycles", last_txn[0].n, 1);

      // Stray acks with no request
      stray_mode = 1'b1;
      repeat (20) @(posedge clk);
      #1 stray_mode = 1'b0;
      do_op(1'b0, 32'h244, 32'h0);
      chk("t5_still_hit", last_stall, 0);

      // Reset during ALLOCATE
      lat_q.push_back(50);
      bus.cpu_addr_i    = 32'h440;
      bus.cpu_MemRead_i = 1'b1;
      waited = 0;
      forever begin
         @(negedge clk);
         if (bus.mem_enable_o && !bus.mem_write_o) break;
         waited++;
         if (waited > 20) begin
            chk("t6_reach_allocate", bus.mem_enable_o, 1);
            break;
         end
      end
      @(posedge clk);
      #1;
      rst               = 1'b1;
      bus.cpu_MemRead_i = 1'b0;
      @(posedge clk);
      @(negedge clk);
      chk("t6_enable_after_rst", bus.mem_enable_o, 0);
      chk("t6_stall_after_rst", bus.cpu_stall_o, 0);
      @(posedge clk);
      #1 rst = 1'b0;
      for (int i = 0; i < NUM_LINES; i++) begin
         m_valid[i] = 1'b0;
         m_dirty[i] = 1'b0;
      end
      chk("t6_no_txn", txn_q.size(), 0);
      txn_q.delete();
      lat_q.delete();
      do_op(1'b0, 32'h240, 32'h0);
      chk("t6_miss_after_rst", (last_stall > 0), 1);

      // Randomized traffic over 4 tags x 16 indices
      for (int n = 0; n < 400; n++) begin
         logic [31:0] a;
         int          gap;
         a = ($urandom_range(0, 3) << 9) | ($urandom_range(0, 15) << 5) | ($urandom_range(0, 7) << 2);
         do_op(1'($urandom_range(0, 1)), a, $urandom());
         gap = $urandom_range(0, 2);
         repeat (gap) begin
            @(posedge clk);
            #1;
         end
      end

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
      $finish;
   end

endmodule
`default_nettype wire

// File: doc/dcache_controller.md
Name: dcache_controller

Overview:
- Direct-mapped, write-back, write-allocate L1 data cache between the CPU memory stage and a 256-bit-line off-chip data memory.
- Replaces the ideal single-cycle data memory seen by the MEM stage.
- Serves hits combinationally with no stall; on a miss it holds the pipeline via cpu_stall_o while an FSM writes back the dirty victim and refills the line.

Parameters:
- NUM_LINES, 16, number of cache lines (power of 2); index width IDX_W = log2(NUM_LINES).
- LINE_BYTES, 32, bytes per line; offset width OFF_W = 5; line width 256.
- TAG_W, 32-IDX_W-OFF_W (23 at defaults), tag bits per line.

Ports:
- clk_i  in  1  clock; all state updates on rising edge.
- rst_i  in  1  synchronous, active-high reset.
- cpu_addr_i  in  32  byte address from MEM stage; bits [1:0] ignored.
- cpu_data_i  in  32  store data.
- cpu_MemRead_i  in  1  load request.
- cpu_MemWrite_i  in  1  store request.
- cpu_data_o  out  32  load data; valid when cpu_MemRead_i=1 and cpu_stall_o=0.
- cpu_stall_o  out  1  freeze PC and all pipeline registers while high.
- mem_addr_o  out  32  line-aligned address; [4:0]=0.
- mem_data_o  out  256  write-back line data.
- mem_enable_o  out  1  memory request; held high until ack.
- mem_write_o  out  1  1 = write-back, 0 = refill; meaningful only with mem_enable_o.
- mem_data_i  in  256  refill data; valid in the ack cycle.
- mem_ack_i  in  1  one-cycle pulse completing the current request.

Behaviour:
- Address split: tag=[31:31-TAG_W+1], index=[OFF_W+IDX_W-1:OFF_W], word=[4:2].
- req = MemRead|MemWrite. hit = req & valid[index] & (tag match). Both read and write high at once is illegal; treat it as a write and flag it with a simulation assertion.
- Reset: every valid and dirty bit cleared; state=IDLE. Outputs: mem_enable_o=0, mem_write_o=0, cpu_stall_o=0, cpu_data_o=0.
- Reset mid-transaction aborts it: enable drops the next cycle and no partial line is written.
- cpu_stall_o = (req & ~hit & state==IDLE) | (state!=IDLE). It is combinational and asserts in the same cycle as the miss.
- cpu_data_o = selected word of the indexed line when MemRead and hit; otherwise 0.
- Write hit in IDLE: the word is written at the clock edge and dirty[index] is set. Tag and valid are unchanged.
- FSM states: IDLE, MISS, WRITEBACK, ALLOCATE.
  - IDLE: if req & ~hit, go to MISS.
  - MISS: enable=0. If valid & dirty, go to WRITEBACK; else go to ALLOCATE.
  - WRITEBACK: enable=1, write=1, addr={victim tag, index, 0}, data=victim line. On ack: clear dirty[index], go to MISS. This gives exactly one enable-low cycle between transactions.
  - ALLOCATE: enable=1, write=0, addr={req tag, index, 0}. On ack: line=mem_data_i, tag=req tag, valid=1, dirty=0, go to IDLE. The request now hits; a store is applied in that IDLE cycle.
- CPU contract: address, data and request are held stable while stall is high.
- Memory contract: mem_addr_o and mem_write_o are stable while enable is high. The ack may arrive on the first enable cycle.
- Latency, with N = enable-high cycles including the ack cycle:
  - Clean miss: N+2 stall cycles.
  - Dirty miss: M+N+3 stall cycles (M write-back, N refill).
  - Hit: 0.
- Ack outside WRITEBACK/ALLOCATE is ignored.

Decomposition:
- Package dcache_pkg holds:
  - state enum (IDLE, MISS, WRITEBACK, ALLOCATE);
  - localparams for OFF_W, IDX_W, TAG_W and line width;
  - a line-metadata typedef {valid, dirty, tag}.
- Sub-module dcache_sram holds the tag/valid/dirty array and the 256-bit data array. It has one combinational read port by index and one write port with write-enable, full-line and word-select modes.
- Controller FSM, hit logic and muxing stay in dcache_controller.

Test Plan:
- After reset, load 0x0000_0040 with memory acking on the 4th enable cycle -> MISS then ALLOCATE with addr 0x40, write=0; stall high 6 cycles; then load returns word 0 of the line; valid[2]=1.
- Store 0xDEADBEEF to 0x44, then load 0x44 -> both hit with zero stall; load returns 0xDEADBEEF; dirty[2]=1.
- Load 0x0000_0240 (same index 2, new tag) -> WRITEBACK addr 0x40 with word 1=0xDEADBEEF, one enable-low cycle, then ALLOCATE addr 0x240; stall M+N+3 cycles.
- Ack on the first enable cycle for a clean refill -> stall exactly 3 cycles; enable high exactly 1 cycle.
- Assert rst_i during ALLOCATE -> next cycle enable=0, state IDLE, all valid bits 0; a later load of 0x240 misses.
- No request with random mem_ack_i pulses -> no state change; stall=0; cpu_data_o=0.
